// File: rtl/qdec_ctx_init_mc.sv
// Multi-lane CABAC context initializer: slope/offset derivation from packed initValue ROM.
// Optional QDEC_CTX_INIT_CHECKSUM_EN adds a 16-bit running checksum of written contexts.
module qdec_ctx_init_mc #(
  parameter int NUM_CTX = 566,
  parameter int LANES   = 2,
  parameter int BEATS   = (NUM_CTX + LANES - 1) / LANES,
  parameter int CTX_AW  = $clog2(NUM_CTX),
  parameter int ROM_AW  = $clog2(3 * BEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ctx_init_start,
  input  logic                 ctx_init_abort,
  input  logic [5:0]           qp,
  input  logic [1:0]           init_type,
  output logic [ROM_AW-1:0]    rom_rd_addr,
  output logic                 rom_rd_en,
  input  logic [8*LANES-1:0]   rom_rdata,
  output logic [CTX_AW-1:0]    ctx_init_addr,
  output logic [7*LANES-1:0]   ctx_init_wdata,
  output logic [LANES-1:0]     ctx_init_we,
  output logic                 ctx_init_busy,
  output logic                 ctx_init_done_intr
`ifdef QDEC_CTX_INIT_CHECKSUM_EN
  ,
  output logic [15:0]          ctx_init_checksum
`endif
);

  localparam int BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSH = $clog2(LANES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic            drain_cnt;
  logic [1:0]      type_q;
  logic [5:0]      qp_q;
  logic            vld_p0;
  logic [BW-1:0]   beat_p0;
  logic [LANES-1:0]   lane_we;
  logic [7*LANES-1:0] wdata_nxt;
  logic [15:0]        lane_sum;
  logic               accept;

  function automatic logic signed [14:0] clip3_1_126(input logic signed [14:0] x);
    if (x < 15'sd1)        return 15'sd1;
    else if (x > 15'sd126) return 15'sd126;
    else                   return x;
  endfunction

  // Product needs 13 bits signed (-45*51 = -2295); 15 bits leaves headroom for the offset add.
  function automatic logic [6:0] ctx_state(input logic [7:0] v, input logic [5:0] q);
    logic signed [7:0]  m;
    logic signed [7:0]  n;
    logic signed [14:0] prod;
    logic signed [14:0] pre;
    logic               mps;
    logic [5:0]         pst;
    m    = 8'sd5 * $signed({4'b0000, v[7:4]}) - 8'sd45;
    n    = $signed({1'b0, v[3:0], 3'b000}) - 8'sd16;
    prod = 15'(m) * $signed({9'b0, q});
    pre  = clip3_1_126((prod >>> 4) + 15'(n));
    mps  = (pre > 15'sd63);
    pst  = mps ? 6'(pre - 15'sd64) : 6'(15'sd63 - pre);
    return {pst, mps};
  endfunction

  assign accept      = (state == S_IDLE) && ctx_init_start && !ctx_init_abort;
  assign rom_rd_en   = (state == S_SCAN);
  assign rom_rd_addr = rom_rd_en ? (ROM_AW'(type_q) * ROM_AW'(BEATS) + ROM_AW'(beat_cnt)) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      beat_cnt           <= '0;
      drain_cnt          <= 1'b0;
      ctx_init_busy      <= 1'b0;
      ctx_init_done_intr <= 1'b0;
    end else begin
      ctx_init_done_intr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_SCAN;
            beat_cnt      <= '0;
            type_q        <= (init_type == 2'd3) ? 2'd0 : init_type;
            qp_q          <= (qp > 6'd51) ? 6'd51 : qp;
            ctx_init_busy <= 1'b1;
          end
        end
        S_SCAN: begin
          if (ctx_init_abort) begin
            state         <= S_IDLE;
            ctx_init_busy <= 1'b0;
          end else if (beat_cnt == LAST_BEAT) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (ctx_init_abort) begin
            state         <= S_IDLE;
            ctx_init_busy <= 1'b0;
          end else if (drain_cnt) begin
            state              <= S_DONE;
            ctx_init_done_intr <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: begin
          state         <= S_IDLE;
          ctx_init_busy <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    lane_we   = '0;
    wdata_nxt = '0;
    lane_sum  = 16'd0;
    for (int i = 0; i < LANES; i++) begin
      lane_we[i] = vld_p0 && ((int'(beat_p0) * LANES + i) < NUM_CTX);
      wdata_nxt[7*i +: 7] = ctx_state(rom_rdata[8*i +: 8], qp_q);
      if (lane_we[i]) lane_sum = lane_sum + 16'(wdata_nxt[7*i +: 7]);
    end
  end

  // p0: ROM read issued last cycle, data on rom_rdata now; p1: registered write outputs
  always_ff @(posedge clk) begin
    beat_p0 <= beat_cnt;
    if (!rst_n) begin
      vld_p0         <= 1'b0;
      ctx_init_we    <= '0;
      ctx_init_addr  <= '0;
      ctx_init_wdata <= '0;
    end else begin
      vld_p0 <= rom_rd_en && !ctx_init_abort;
      if (vld_p0 && !ctx_init_abort) begin
        ctx_init_we    <= lane_we;
        ctx_init_addr  <= CTX_AW'(beat_p0) << LSH;
        ctx_init_wdata <= wdata_nxt;
      end else begin
        ctx_init_we <= '0;
      end
    end
  end

`ifdef QDEC_CTX_INIT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                        ctx_init_checksum <= 16'd0;
    else if (accept)                   ctx_init_checksum <= 16'd0;
    else if (vld_p0 && !ctx_init_abort) ctx_init_checksum <= ctx_init_checksum + lane_sum;
  end
`endif

endmodule
